// File: rtl/icache_pkg.sv
//------------------------------------------------------------------------------
// icache_pkg : shared geometry constants and FSM state type for the icache
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package icache_pkg;

  localparam int unsigned ICACHE_LINE_BYTES = 16;
  localparam int unsigned ICACHE_NUM_LINES  = 16;
  localparam int unsigned ICACHE_ADDR_W     = 32;
  localparam int unsigned ICACHE_WORD_W     = 32;

  localparam int unsigned ICACHE_OFF_W  = $clog2(ICACHE_LINE_BYTES);
  localparam int unsigned ICACHE_IDX_W  = $clog2(ICACHE_NUM_LINES);
  localparam int unsigned ICACHE_TAG_W  = ICACHE_ADDR_W - ICACHE_OFF_W - ICACHE_IDX_W;
  localparam int unsigned ICACHE_LINE_W = 8 * ICACHE_LINE_BYTES;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } icache_state_e;

endpackage

`default_nettype wire

// File: rtl/icache_if.sv
//------------------------------------------------------------------------------
// icache_if : fetcher-side and memory-controller-side signals of the icache
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface icache_if #(
  parameter int unsigned ADDR_W     = icache_pkg::ICACHE_ADDR_W,
  parameter int unsigned LINE_BYTES = icache_pkg::ICACHE_LINE_BYTES
);

  logic                    fetch_en;
  logic [ADDR_W-1:0]       fetch_pc;
  logic                    fetch_hit;
  logic [31:0]             fetch_inst;

  logic                    if_en;
  logic [ADDR_W-1:0]       if_pc;
  logic                    if_done;
  logic [8*LINE_BYTES-1:0] if_data;

  // master = fetcher plus memory controller, slave = the cache
  modport master (
    output fetch_en, fetch_pc, if_done, if_data,
    input  fetch_hit, fetch_inst, if_en, if_pc
  );

  modport slave (
    input  fetch_en, fetch_pc, if_done, if_data,
    output fetch_hit, fetch_inst, if_en, if_pc
  );

endinterface

`default_nettype wire

// File: rtl/icache_line_store.sv
//------------------------------------------------------------------------------
// icache_line_store : valid/tag/data arrays, one combinational read, one write
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module icache_line_store #(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES),
  parameter int unsigned TAG_W     = 24,
  parameter int unsigned LINE_W    = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [LINE_W-1:0]    data_d [NUM_LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end

  // Only the valid bits need a known value after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

`default_nettype wire

// File: rtl/icache.sv
//------------------------------------------------------------------------------
// icache : direct-mapped read-only instruction cache with single-line refill
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINE_BYTES = ICACHE_LINE_BYTES,
  parameter int unsigned NUM_LINES  = ICACHE_NUM_LINES,
  parameter int unsigned ADDR_W     = ICACHE_ADDR_W
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     rollback,
  icache_if.slave  bus
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned LINE_W = 8 * LINE_BYTES;
  localparam int unsigned WORDS  = LINE_BYTES / 4;

  icache_state_e     state_q, state_d;
  logic              if_en_q, if_en_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;

  logic [IDX_W-1:0]   pc_idx;
  logic [TAG_W-1:0]   pc_tag;
  logic [OFF_W-3:0]   word_sel;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [LINE_W-1:0]  rd_data;
  logic               lookup_hit;
  logic               wr_en;
  logic [31:0]        line_words [WORDS];
  logic               unused_pc_bits;

  assign pc_idx         = bus.fetch_pc[OFF_W +: IDX_W];
  assign pc_tag         = bus.fetch_pc[ADDR_W-1 -: TAG_W];
  assign word_sel       = bus.fetch_pc[OFF_W-1:2];
  assign unused_pc_bits = ^bus.fetch_pc[1:0];

  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .LINE_W    (LINE_W)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (fill_idx_q),
    .wr_tag   (fill_tag_q),
    .wr_data  (bus.if_data)
  );

  generate
    for (genvar i = 0; i < WORDS; i++) begin : g_words
      assign line_words[i] = rd_data[32*i +: 32];
    end
  endgenerate

  assign lookup_hit     = rd_valid && (rd_tag == pc_tag);
  assign bus.fetch_hit  = rdy && bus.fetch_en && (state_q == ST_IDLE) && lookup_hit;
  assign bus.fetch_inst = line_words[word_sel];

  // Install only on a live cycle; a done pulse seen outside FILL is ignored
  assign wr_en = rdy && (state_q == ST_FILL) && bus.if_done;

  always_comb begin
    state_d    = state_q;
    if_en_d    = if_en_q;
    if_pc_d    = if_pc_q;
    fill_idx_d = fill_idx_q;
    fill_tag_d = fill_tag_q;
    case (state_q)
      ST_IDLE: begin
        // A miss under rollback is for a PC that is being redirected away
        if (bus.fetch_en && !lookup_hit && !rollback) begin
          state_d    = ST_FILL;
          if_en_d    = 1'b1;
          if_pc_d    = {pc_tag, pc_idx, {OFF_W{1'b0}}};
          fill_idx_d = pc_idx;
          fill_tag_d = pc_tag;
        end
      end
      ST_FILL: begin
        // Controller transfers cannot be aborted, so rollback is ignored here
        if (bus.if_done) begin
          state_d = ST_IDLE;
          if_en_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      if_en_q    <= 1'b0;
      if_pc_q    <= '0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      if_en_q    <= if_en_d;
      if_pc_q    <= if_pc_d;
      fill_idx_q <= fill_idx_d;
      fill_tag_q <= fill_tag_d;
    end
  end

  assign bus.if_en = if_en_q;
  assign bus.if_pc = if_pc_q;

endmodule

`default_nettype wire
